// File: rtl/sysid_checker.sv
// sysid_checker: Avalon-MM read master that fetches the system ID and
// build timestamp words and reports whether they match the build.
module sysid_checker #(
   parameter logic [31:0] EXPECTED_ID        = 32'h0E67BD8D,
   parameter logic [31:0] EXPECTED_TIMESTAMP = 32'h52013E60,
   parameter int unsigned TIMEOUT_CYCLES     = 255,
   parameter bit          AUTO_START         = 1'b1
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   output logic        avm_address,
   output logic        avm_read,
   input  logic        avm_waitrequest,
   input  logic [31:0] avm_readdata,
   input  logic        avm_readdatavalid,
   output logic        busy,
   output logic        done,
   output logic        id_ok,
   output logic        ts_ok,
   output logic        timeout,
   output logic [31:0] id_value,
   output logic [31:0] ts_value
);

   localparam logic [2:0] S_IDLE    = 3'd0;
   localparam logic [2:0] S_ID_REQ  = 3'd1;
   localparam logic [2:0] S_ID_WAIT = 3'd2;
   localparam logic [2:0] S_TS_REQ  = 3'd3;
   localparam logic [2:0] S_TS_WAIT = 3'd4;
   localparam logic [2:0] S_FINISH  = 3'd5;

   // last count value still inside the per-read budget
   localparam logic [15:0] CNT_LAST = 16'(TIMEOUT_CYCLES - 32'd1);

   logic [2:0]  state_q, state_d;
   logic [15:0] cnt_q, cnt_d;
   logic        pend_q, pend_d;
   logic        read_q, read_d;
   logic        addr_q, addr_d;
   logic        busy_q, busy_d;
   logic        done_q, done_d;
   logic        id_ok_q, id_ok_d;
   logic        ts_ok_q, ts_ok_d;
   logic        tmo_q, tmo_d;
   logic [31:0] id_val_q, id_val_d;
   logic [31:0] ts_val_q, ts_val_d;

   logic expire;
   logic accept;

   assign expire = (cnt_q == CNT_LAST);
   assign accept = ~avm_waitrequest;

   // sequencer: next state, timeout counter and result capture
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      pend_d   = pend_q;
      id_ok_d  = id_ok_q;
      ts_ok_d  = ts_ok_q;
      tmo_d    = tmo_q;
      id_val_d = id_val_q;
      ts_val_d = ts_val_q;
      unique case (state_q)
         S_IDLE: begin
            if (pend_q || start) begin
               state_d  = S_ID_REQ;
               pend_d   = 1'b0;
               cnt_d    = 16'd0;
               id_ok_d  = 1'b0;
               ts_ok_d  = 1'b0;
               tmo_d    = 1'b0;
               id_val_d = 32'd0;
               ts_val_d = 32'd0;
            end
         end
         S_ID_REQ: begin
            cnt_d = cnt_q + 16'd1;
            if (accept && avm_readdatavalid) begin
               id_val_d = avm_readdata;
               id_ok_d  = (avm_readdata == EXPECTED_ID);
               state_d  = S_TS_REQ;
               cnt_d    = 16'd0;
            end else if (expire) begin
               tmo_d   = 1'b1;
               state_d = S_FINISH;
            end else if (accept) begin
               state_d = S_ID_WAIT;
            end
         end
         S_ID_WAIT: begin
            cnt_d = cnt_q + 16'd1;
            if (avm_readdatavalid) begin
               id_val_d = avm_readdata;
               id_ok_d  = (avm_readdata == EXPECTED_ID);
               state_d  = S_TS_REQ;
               cnt_d    = 16'd0;
            end else if (expire) begin
               tmo_d   = 1'b1;
               state_d = S_FINISH;
            end
         end
         S_TS_REQ: begin
            cnt_d = cnt_q + 16'd1;
            if (accept && avm_readdatavalid) begin
               ts_val_d = avm_readdata;
               ts_ok_d  = (avm_readdata == EXPECTED_TIMESTAMP);
               state_d  = S_FINISH;
            end else if (expire) begin
               tmo_d   = 1'b1;
               state_d = S_FINISH;
            end else if (accept) begin
               state_d = S_TS_WAIT;
            end
         end
         S_TS_WAIT: begin
            cnt_d = cnt_q + 16'd1;
            if (avm_readdatavalid) begin
               ts_val_d = avm_readdata;
               ts_ok_d  = (avm_readdata == EXPECTED_TIMESTAMP);
               state_d  = S_FINISH;
            end else if (expire) begin
               tmo_d   = 1'b1;
               state_d = S_FINISH;
            end
         end
         S_FINISH: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // bus and status outputs are registered copies of the next state
   always_comb begin
      read_d = (state_d == S_ID_REQ) || (state_d == S_TS_REQ);
      addr_d = (state_d == S_TS_REQ);
      busy_d = (state_d != S_IDLE);
      done_d = (state_d == S_FINISH);
   end

   // state registers; reset re-arms the automatic check
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q  <= S_IDLE;
         cnt_q    <= 16'd0;
         pend_q   <= AUTO_START;
         read_q   <= 1'b0;
         addr_q   <= 1'b0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         id_ok_q  <= 1'b0;
         ts_ok_q  <= 1'b0;
         tmo_q    <= 1'b0;
         id_val_q <= 32'd0;
         ts_val_q <= 32'd0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         pend_q   <= pend_d;
         read_q   <= read_d;
         addr_q   <= addr_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
         id_ok_q  <= id_ok_d;
         ts_ok_q  <= ts_ok_d;
         tmo_q    <= tmo_d;
         id_val_q <= id_val_d;
         ts_val_q <= ts_val_d;
      end
   end

   assign avm_read    = read_q;
   assign avm_address = addr_q;
   assign busy        = busy_q;
   assign done        = done_q;
   assign id_ok       = id_ok_q;
   assign ts_ok       = ts_ok_q;
   assign timeout     = tmo_q;
   assign id_value    = id_val_q;
   assign ts_value    = ts_val_q;

endmodule

// File: tb/tb_sysid_checker.sv
// tb_sysid_checker: reactive Avalon slave, timeline model of the expected
// per-cycle outputs, and directed scenarios with literal expectations.
module tb_sysid_checker;

   localparam int N = 1024;
   localparam int TMO = 10;
   localparam logic [31:0] EXP_ID = 32'h0E67BD8D;
   localparam logic [31:0] EXP_TS = 32'h52013E60;

   logic clk = 1'b0;
   logic reset = 1'b1;
   logic start = 1'b0;
   logic avm_address, avm_read, avm_waitrequest, avm_readdatavalid;
   logic [31:0] avm_readdata;
   logic busy, done, id_ok, ts_ok, timeout;
   logic [31:0] id_value, ts_value;

   int checks = 0;
   int failures = 0;
   int cyc = 0;
   bit chk_en = 1'b0;
   int done_cnt = 0;
   int last_done = -1;

   // slave configuration
   int sw = 0;
   int sl = 1;
   bit snv = 1'b0;
   logic [31:0] w0 = EXP_ID;
   logic [31:0] w1 = EXP_TS;

   // slave state
   int stall_cnt = 0;
   int cd = 0;
   bit valid_r = 1'b0;
   logic [31:0] rdata_r = 32'd0;
   int acc_cnt = 0;
   int acc_ts = 0;

   // expected per-cycle outputs
   bit e_rd[N];
   bit e_ad[N];
   bit e_bs[N];
   bit e_dn[N];
   bit e_io[N];
   bit e_to[N];
   bit e_tm[N];
   bit [31:0] e_iv[N];
   bit [31:0] e_tv[N];

   sysid_checker #(
      .EXPECTED_ID       (EXP_ID),
      .EXPECTED_TIMESTAMP(EXP_TS),
      .TIMEOUT_CYCLES    (TMO),
      .AUTO_START        (1'b1)
   ) dut (
      .clk              (clk),
      .reset            (reset),
      .start            (start),
      .avm_address      (avm_address),
      .avm_read         (avm_read),
      .avm_waitrequest  (avm_waitrequest),
      .avm_readdata     (avm_readdata),
      .avm_readdatavalid(avm_readdatavalid),
      .busy             (busy),
      .done             (done),
      .id_ok            (id_ok),
      .ts_ok            (ts_ok),
      .timeout          (timeout),
      .id_value         (id_value),
      .ts_value         (ts_value)
   );

   initial forever #5 clk = ~clk;

   initial forever begin
      @(posedge clk);
      cyc++;
   end

   assign avm_waitrequest = avm_read && (stall_cnt < sw);
   assign avm_readdatavalid = (sl == 0) ?
      (avm_read && !avm_waitrequest && !snv) : valid_r;
   assign avm_readdata = (sl == 0) ?
      (avm_address ? w1 : w0) : rdata_r;

   // slave: samples the bus mid-cycle, updates after the next edge
   initial begin
      bit n_rd, n_wr, n_ad, n_rs;
      forever begin
         @(negedge clk);
         n_rd = avm_read;
         n_wr = avm_waitrequest;
         n_ad = avm_address;
         n_rs = reset;
         @(posedge clk);
         #1;
         valid_r = 1'b0;
         if (n_rs) begin
            cd = 0;
            stall_cnt = 0;
         end else begin
            if (n_rd && n_wr) stall_cnt++;
            else stall_cnt = 0;
            if (cd > 0) begin
               cd--;
               if (cd == 0) valid_r = 1'b1;
            end
            if (n_rd && !n_wr) begin
               acc_cnt++;
               if (n_ad) acc_ts++;
               if (sl > 0 && !snv) begin
                  rdata_r = n_ad ? w1 : w0;
                  cd = sl - 1;
                  if (cd == 0) valid_r = 1'b1;
               end
            end
         end
      end
   end

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic fill(input int c0, input bit io, input bit to,
                       input bit tm, input bit [31:0] iv,
                       input bit [31:0] tv);
      for (int c = c0; c < N; c++) begin
         e_io[c] = io;
         e_to[c] = to;
         e_tm[c] = tm;
         e_iv[c] = iv;
         e_tv[c] = tv;
      end
   endtask

   // one read: held from r until accepted, data L cycles later,
   // abandoned after TMO cycles counted from r
   task automatic phase(input int r, input bit adr, output bit got,
                        output int last);
      int a, d, lim;
      a = r + sw;
      d = a + sl;
      lim = r + TMO - 1;
      got = !snv && (d <= lim);
      last = got ? d : lim;
      for (int c = r; c <= a && c <= lim && c < N; c++) begin
         e_rd[c] = 1'b1;
         e_ad[c] = adr;
      end
   endtask

   // expected timeline for a sequence whose start is sampled end of cycle s
   task automatic plan(input int s);
      bit got, io, to;
      int last;
      bit [31:0] iv, tv;
      io = 1'b0;
      to = 1'b0;
      iv = 32'd0;
      tv = 32'd0;
      for (int c = s + 1; c < N; c++) begin
         e_rd[c] = 1'b0;
         e_ad[c] = 1'b0;
         e_bs[c] = 1'b0;
         e_dn[c] = 1'b0;
      end
      fill(s + 1, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
      phase(s + 1, 1'b0, got, last);
      if (got) begin
         iv = w0;
         io = (w0 == EXP_ID);
         fill(last + 1, io, 1'b0, 1'b0, iv, 32'd0);
         phase(last + 1, 1'b1, got, last);
         if (got) begin
            tv = w1;
            to = (w1 == EXP_TS);
            fill(last + 1, io, to, 1'b0, iv, tv);
         end
      end
      if (!got) fill(last + 1, io, to, 1'b1, iv, tv);
      for (int c = s + 1; c <= last + 1 && c < N; c++) e_bs[c] = 1'b1;
      if (last + 1 < N) e_dn[last + 1] = 1'b1;
   endtask

   task automatic plan_reset(input int x);
      for (int c = x; c < N; c++) begin
         e_rd[c] = 1'b0;
         e_ad[c] = 1'b0;
         e_bs[c] = 1'b0;
         e_dn[c] = 1'b0;
      end
      fill(x, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
   endtask

   // per-cycle comparison against the timeline model
   initial begin
      logic [70:0] act, exp;
      forever begin
         @(negedge clk);
         if (chk_en && cyc < N) begin
            act = {avm_read, avm_address, busy, done, id_ok, ts_ok,
                   timeout, id_value, ts_value};
            exp = {e_rd[cyc], e_ad[cyc], e_bs[cyc], e_dn[cyc], e_io[cyc],
                   e_to[cyc], e_tm[cyc], e_iv[cyc], e_tv[cyc]};
            checks++;
            if (act !== exp) begin
               failures++;
               $display("FAIL cycle %0d outputs got %h expected %h",
                        cyc, act, exp);
            end
            if (done === 1'b1) begin
               done_cnt++;
               last_done = cyc;
            end
         end
      end
   end

   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic do_start(output int s);
      @(posedge clk);
      #1;
      s = cyc;
      plan(s);
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
   endtask

   initial begin
      int s, c, x, a0, t0, d0;
      repeat (3) @(posedge clk);
      #1;
      chk_en = 1'b1;
      chk("reset_read", avm_read, 32'd0);
      chk("reset_busy", busy, 32'd0);

      // power-on auto start, matching slave, 1-cycle latency
      @(posedge clk);
      #2;
      c = cyc;
      plan(c);
      reset = 1'b0;
      idle(10);
      chk("auto_done_cycle", last_done, c + 5);
      chk("auto_id_ok", id_ok, 32'd1);
      chk("auto_ts_ok", ts_ok, 32'd1);
      chk("auto_timeout", timeout, 32'd0);
      chk("auto_id_value", id_value, 32'h0E67BD8D);

      // wrong timestamp
      w1 = 32'h52013E61;
      d0 = done_cnt;
      do_start(s);
      idle(10);
      chk("badts_id_ok", id_ok, 32'd1);
      chk("badts_ts_ok", ts_ok, 32'd0);
      chk("badts_ts_value", ts_value, 32'h52013E61);
      chk("badts_done_once", done_cnt - d0, 32'd1);
      w1 = EXP_TS;

      // 3-cycle waitrequest stall on each read
      sw = 3;
      a0 = acc_cnt;
      do_start(s);
      idle(16);
      chk("stall_accepts", acc_cnt - a0, 32'd2);
      chk("stall_done_cycle", last_done, s + 11);
      chk("stall_ts_ok", ts_ok, 32'd1);
      sw = 0;

      // slave never answers
      snv = 1'b1;
      a0 = acc_cnt;
      t0 = acc_ts;
      do_start(s);
      idle(16);
      chk("nv_timeout", timeout, 32'd1);
      chk("nv_done_cycle", last_done, s + 11);
      chk("nv_id_value", id_value, 32'd0);
      chk("nv_no_ts_read", acc_ts - t0, 32'd0);
      chk("nv_one_read", acc_cnt - a0, 32'd1);
      snv = 1'b0;

      // start while busy is dropped; later start clears the flags
      d0 = done_cnt;
      do_start(s);
      @(posedge clk);
      #1;
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      idle(12);
      chk("busy_start_dropped", done_cnt - d0, 32'd1);
      w0 = 32'h0E67BD8C;
      do_start(s);
      idle(10);
      chk("second_id_ok", id_ok, 32'd0);
      chk("second_id_value", id_value, 32'h0E67BD8C);
      chk("second_done_cycle", last_done, s + 5);
      w0 = EXP_ID;

      // zero-latency slave
      sl = 0;
      do_start(s);
      idle(8);
      chk("zl_done_cycle", last_done, s + 3);
      chk("zl_ts_ok", ts_ok, 32'd1);

      // data after the deadline is ignored
      sl = 15;
      do_start(s);
      idle(30);
      chk("late_timeout", timeout, 32'd1);
      chk("late_id_value", id_value, 32'd0);
      chk("late_done_cycle", last_done, s + 11);

      // reset during ID_WAIT, then automatic rerun
      sl = 3;
      do_start(s);
      @(posedge clk);
      #2;
      x = cyc;
      reset = 1'b1;
      plan_reset(x);
      #1;
      chk("arst_busy", busy, 32'd0);
      chk("arst_timeout", timeout, 32'd0);
      chk("arst_read", avm_read, 32'd0);
      repeat (2) @(posedge clk);
      #2;
      c = cyc;
      sl = 1;
      plan(c);
      reset = 1'b0;
      idle(10);
      chk("rerun_done_cycle", last_done, c + 5);
      chk("rerun_id_ok", id_ok, 32'd1);
      chk("rerun_ts_ok", ts_ok, 32'd1);

      idle(3);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
